// File: rtl/switch_conditioner_if.sv
// Signal bundle between the raw pad inputs and the conditioned outputs
// that feed the counter/LED display top level.
interface switch_conditioner_if #(
  parameter int N_IN = 4
);
  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] level;
  logic [N_IN-1:0] rise;
  logic [N_IN-1:0] fall;
  logic [N_IN-1:0] toggle;
  logic            any_event;

  // Producer of raw pad levels, consumer of the conditioned outputs.
  modport master (
    output raw_in,
    input  level, rise, fall, toggle, any_event
  );

  // The conditioner itself.
  modport slave (
    input  raw_in,
    output level, rise, fall, toggle, any_event
  );
endinterface

// File: rtl/switch_conditioner.sv
// Push-button / DIP switch conditioner: two-flop synchroniser, per-channel
// debounce counter, clean levels, one-cycle edge pulses and toggle states.
// Every output is a flop; nothing from raw_in reaches an output combinationally.
module switch_conditioner #(
  parameter int N_IN            = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  switch_conditioner_if.slave  sw
);

  // A debounce length outside 1 .. 2^CNT_W cannot be counted; stop at elaboration.
  if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_debounce
    $fatal(1, "switch_conditioner: DEBOUNCE_CYCLES out of range 1 .. 2^CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0] sync1_reg;
  logic [N_IN-1:0] sync2_reg;
  logic [N_IN-1:0] level_reg;
  logic [N_IN-1:0] rise_reg;
  logic [N_IN-1:0] fall_reg;
  logic [N_IN-1:0] toggle_reg;
  logic            any_event_reg;

  logic [N_IN-1:0] rise_next;
  logic [N_IN-1:0] fall_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt_reg;
      logic             pending;
      logic             accept;

      // PENDING while the synchronised input disagrees with the accepted level;
      // the change is accepted on the DEBOUNCE_CYCLES-th consecutive pending edge.
      assign pending        = sync2_reg[gi] != level_reg[gi];
      assign accept         = pending && (cnt_reg == CNT_MAX);
      assign rise_next[gi]  = accept &&  sync2_reg[gi];
      assign fall_next[gi]  = accept && !sync2_reg[gi];

      // Count consecutive pending cycles; any return to agreement or an accept restarts it.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (!pending || accept) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  // Synchroniser, accepted levels, edge pulses, toggles and the combined event flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg     <= '0;
      sync2_reg     <= '0;
      level_reg     <= '0;
      rise_reg      <= '0;
      fall_reg      <= '0;
      toggle_reg    <= '0;
      any_event_reg <= 1'b0;
    end else begin
      sync1_reg     <= sw.raw_in ^ {N_IN{ACTIVE_LOW}};
      sync2_reg     <= sync1_reg;
      level_reg     <= level_reg ^ (rise_next | fall_next);
      rise_reg      <= rise_next;
      fall_reg      <= fall_next;
      toggle_reg    <= toggle_reg ^ rise_next;
      any_event_reg <= |(rise_next | fall_next);
    end
  end

  assign sw.level     = level_reg;
  assign sw.rise      = rise_reg;
  assign sw.fall      = fall_reg;
  assign sw.toggle    = toggle_reg;
  assign sw.any_event = any_event_reg;

endmodule

// File: tb/tb_switch_conditioner.sv
// Self-checking bench for switch_conditioner (N_IN=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1).
// Reference model: an input is accepted once the last D synchronised samples
// all disagree with the accepted level.
module tb_switch_conditioner;
  localparam int N = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;

  switch_conditioner_if #(.N_IN(N)) sif ();

  switch_conditioner #(
    .N_IN(N), .DEBOUNCE_CYCLES(D), .CNT_W(20), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sif)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [N-1:0] m_sync1, m_sync2, m_level, m_rise, m_fall, m_toggle;
  logic         m_any;
  bit           hist [N][$];
  int           rise_seen [N];
  int           fall_seen [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  task automatic check_all();
    check("level",     {28'b0, sif.level},     {28'b0, m_level});
    check("rise",      {28'b0, sif.rise},      {28'b0, m_rise});
    check("fall",      {28'b0, sif.fall},      {28'b0, m_fall});
    check("toggle",    {28'b0, sif.toggle},    {28'b0, m_toggle});
    check("any_event", {31'b0, sif.any_event}, {31'b0, m_any});
  endtask

  task automatic model_clear();
    m_sync1 = '0; m_sync2 = '0; m_level = '0; m_rise = '0;
    m_fall = '0; m_toggle = '0; m_any = 1'b0;
    for (int c = 0; c < N; c++) hist[c].delete();
  endtask

  // Advance the model by one rising edge, let the DUT take the edge, compare.
  task automatic tick();
    logic [N-1:0] nr, nf;
    bit all_diff;
    if (reset) begin
      model_clear();
    end else begin
      nr = '0;
      nf = '0;
      for (int c = 0; c < N; c++) begin
        hist[c].push_back(m_sync2[c]);
        if (hist[c].size() > D) void'(hist[c].pop_front());
        if (hist[c].size() == D) begin
          all_diff = 1'b1;
          for (int k = 0; k < D; k++) if (hist[c][k] == m_level[c]) all_diff = 1'b0;
          if (all_diff) begin
            if (m_level[c]) nf[c] = 1'b1;
            else            nr[c] = 1'b1;
          end
        end
      end
      m_level  = m_level ^ (nr | nf);
      m_toggle = m_toggle ^ nr;
      m_rise   = nr;
      m_fall   = nf;
      m_any    = |(nr | nf);
      m_sync2  = m_sync1;
      m_sync1  = ~sif.raw_in;
    end
    @(posedge clk);
    #1;
    cycle++;
    for (int c = 0; c < N; c++) begin
      if (sif.rise[c]) rise_seen[c]++;
      if (sif.fall[c]) fall_seen[c]++;
    end
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset pulse, asserted between edges.
  task automatic do_reset(input int n);
    reset = 1'b1;
    model_clear();
    #1;
    check_all();
    ticks(n);
    reset = 1'b0;
  endtask

  initial begin
    int r0, f0;
    sif.raw_in = 4'hF;
    for (int c = 0; c < N; c++) begin rise_seen[c] = 0; fall_seen[c] = 0; end
    model_clear();
    @(posedge clk);
    #1;

    // Reset values
    do_reset(3);
    ticks(10);
    check("reset_level_zero", {28'b0, sif.level}, 32'h0);
    $display("[TB] reset: outputs held at zero for 10 cycles after release");

    // Clean press on ch0, driven just after edge 0
    sif.raw_in[0] = 1'b0;
    ticks(5);
    check("press_no_rise_edge5", {31'b0, sif.rise[0]}, 32'h0);
    tick();
    check("press_rise_edge6",   {31'b0, sif.rise[0]},   32'h1);
    check("press_level_edge6",  {31'b0, sif.level[0]},  32'h1);
    check("press_toggle_edge6", {31'b0, sif.toggle[0]}, 32'h1);
    check("press_any_edge6",    {31'b0, sif.any_event}, 32'h1);
    tick();
    check("press_rise_width",   {31'b0, sif.rise[0]},   32'h0);
    ticks(4);
    $display("[TB] clean press ch0: rise at edge 6");

    // Bounce rejection on ch1: 3-cycle segments for 30 cycles, then hold high
    r0 = rise_seen[1];
    f0 = fall_seen[1];
    for (int s = 0; s < 10; s++) begin
      sif.raw_in[1] = s[0];
      ticks(3);
    end
    sif.raw_in[1] = 1'b1;
    ticks(8);
    check("bounce_level1", {31'b0, sif.level[1]}, 32'h0);
    check("bounce_rises1", rise_seen[1] - r0, 32'h0);
    check("bounce_falls1", fall_seen[1] - f0, 32'h0);
    $display("[TB] bounce ch1: no level change");

    // Toggle and release on ch2, twice
    r0 = rise_seen[2];
    f0 = fall_seen[2];
    for (int p = 0; p < 2; p++) begin
      sif.raw_in[2] = 1'b0;
      ticks(10);
      check("tog_after_press",   {31'b0, sif.toggle[2]}, (p == 0) ? 32'h1 : 32'h0);
      sif.raw_in[2] = 1'b1;
      ticks(10);
      check("tog_after_release", {31'b0, sif.toggle[2]}, (p == 0) ? 32'h1 : 32'h0);
    end
    check("tog_rise_count", rise_seen[2] - r0, 32'h2);
    check("tog_fall_count", fall_seen[2] - f0, 32'h2);
    $display("[TB] toggle ch2: two press/release pairs");

    // Simultaneous ch0 and ch3: release everything, then drop both together
    sif.raw_in = 4'hF;
    ticks(12);
    sif.raw_in[0] = 1'b0;
    sif.raw_in[3] = 1'b0;
    ticks(6);
    check("simul_rise", {28'b0, sif.rise},      32'h9);
    check("simul_any",  {31'b0, sif.any_event}, 32'h1);
    tick();
    check("simul_any_width", {31'b0, sif.any_event}, 32'h0);
    ticks(4);
    $display("[TB] simultaneous ch0/ch3 rise");

    // Reset mid-debounce on ch1
    sif.raw_in = 4'hF;
    ticks(12);
    r0 = rise_seen[1];
    sif.raw_in[1] = 1'b0;
    ticks(4);
    check("midrst_no_pulse", rise_seen[1] - r0, 32'h0);
    do_reset(2);
    ticks(5);
    check("midrst_no_rise_yet", {31'b0, sif.rise[1]}, 32'h0);
    tick();
    check("midrst_rise_edge6",  {31'b0, sif.rise[1]}, 32'h1);
    ticks(3);
    $display("[TB] reset mid-debounce ch1: rise 6 edges after release");

    // Randomised activity against the model, with occasional resets
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 5) == 0) sif.raw_in[c] = ~sif.raw_in[c];
      if ($urandom_range(0, 399) == 0) do_reset($urandom_range(1, 3));
      else tick();
    end
    $display("[TB] random phase: 1500 steps");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
